// File: rtl/vidc_reg_snoop.sv
// Decodes async VIDC register writes into palette/cursor/timing shadows and a special-event stream; outputs move SYNC_STAGES+MIN_LOW+1 clk after nVIDW falls.
// No backpressure: one write per low pulse, each completed in one cycle; VIDC_WRITE_LOG_EN adds a 16-deep raw-write log that drops and counts on overflow.

`ifdef VIDC_WRITE_LOG_EN
module vidc_log_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_push_vld,
    input  logic [W-1:0] i_push_dat,
    input  logic         i_pop_rdy,
    output logic [W-1:0] o_head_dat,
    output logic         o_empty,
    output logic         o_full
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr_ptr;
    logic [AW:0]  r_rd_ptr;
    logic         w_do_pop;
    logic         w_do_push;

    assign o_empty    = (r_wr_ptr == r_rd_ptr);
    assign o_full     = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_do_pop   = i_pop_rdy && !o_empty;
    // A pop frees the slot this cycle, so a push into a full FIFO still lands.
    assign w_do_push  = i_push_vld && (!o_full || w_do_pop);
    assign o_head_dat = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wr_ptr[AW-1:0]] <= i_push_dat;
                r_wr_ptr                <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end
endmodule
`endif

module vidc_reg_snoop #(
    parameter int SYNC_STAGES = 2,
    parameter int MIN_LOW     = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         vidc_nvidw,
    input  logic [31:0]  vidc_d,
    output logic [191:0] vidc_palette,
    output logic [35:0]  vidc_cursor_palette,
    output logic [10:0]  v_cursor_x,
    output logic [9:0]   v_cursor_y,
    output logic [9:0]   v_cursor_yend,
    output logic         vidc_special_written,
    output logic [23:0]  vidc_special,
    output logic [23:0]  vidc_special_data,
    output logic         vidc_tregs_status,
    input  logic         vidc_tregs_ack,
    input  logic [3:0]   treg_sel,
    output logic [23:0]  treg_rdata
`ifdef VIDC_WRITE_LOG_EN
    ,
    input  logic         log_rd,
    output logic [31:0]  log_data,
    output logic         log_empty,
    output logic [7:0]   log_ovf
`endif
);
    localparam int             CW    = $clog2(MIN_LOW + 1);
    localparam logic [CW-1:0]  C_MIN = CW'(MIN_LOW);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] r_sync_vld;
    logic [CW-1:0]          r_cnt;
    logic                   r_armed;
    logic                   r_ack_q;
    logic [191:0]           r_palette;
    logic [35:0]            r_cpal;
    logic [10:0]            r_cur_x;
    logic [9:0]             r_cur_y;
    logic [9:0]             r_cur_yend;
    logic                   r_spec_wr;
    logic [23:0]            r_spec;
    logic [23:0]            r_spec_dat;
    logic                   r_tregs_status;
    logic [23:0]            r_treg [16];

    logic       w_sync;
    logic       w_accept;
    logic [7:0] w_addr;
    logic       w_is_pal;
    logic       w_is_cur;
    logic       w_is_treg;
    logic       w_treg_chg;
    logic       w_ack_rise;

    assign w_sync     = r_sync[SYNC_STAGES-1];
    assign w_accept   = r_armed && (r_cnt == C_MIN);
    assign w_addr     = vidc_d[31:24];
    assign w_is_pal   = (w_addr[7:6] == 2'b00);
    assign w_is_cur   = (w_addr == 8'h44) || (w_addr == 8'h48) || (w_addr == 8'h4C);
    assign w_is_treg  = (w_addr[7:6] == 2'b10);
    assign w_treg_chg = w_accept && w_is_treg && (r_treg[w_addr[5:2]] != vidc_d[23:0]);
    assign w_ack_rise = vidc_tregs_ack && !r_ack_q;

    // r_sync_vld marks when the chain holds real samples, so the reset-time
    // idle value cannot re-arm a strobe that was already low through reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_sync     <= '1;
            r_sync_vld <= '0;
            r_cnt      <= '0;
            r_armed    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], vidc_nvidw};
            r_sync_vld <= {r_sync_vld[SYNC_STAGES-2:0], 1'b1};
            if (w_sync) begin
                r_cnt <= '0;
            end else if (r_cnt != C_MIN) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_accept) begin
                r_armed <= 1'b0;
            end else if (w_sync && r_sync_vld[SYNC_STAGES-1]) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_ack_q        <= 1'b0;
            r_palette      <= '0;
            r_cpal         <= '0;
            r_cur_x        <= '0;
            r_cur_y        <= '0;
            r_cur_yend     <= '0;
            r_spec_wr      <= 1'b0;
            r_spec         <= '0;
            r_spec_dat     <= '0;
            r_tregs_status <= 1'b0;
            for (int i = 0; i < 16; i++) begin
                r_treg[i] <= '0;
            end
        end else begin
            r_ack_q   <= vidc_tregs_ack;
            r_spec_wr <= 1'b0;
            if (w_accept) begin
                if (w_is_pal) begin
                    r_palette[w_addr[5:2]*12 +: 12] <= vidc_d[11:0];
                end else if (w_is_cur) begin
                    case (w_addr[3:2])
                        2'd1:    r_cpal[0  +: 12] <= vidc_d[11:0];
                        2'd2:    r_cpal[12 +: 12] <= vidc_d[11:0];
                        default: r_cpal[24 +: 12] <= vidc_d[11:0];
                    endcase
                end else if (w_is_treg) begin
                    r_treg[w_addr[5:2]] <= vidc_d[23:0];
                    if (w_addr == 8'h98) r_cur_x    <= vidc_d[23:13];
                    if (w_addr == 8'hB8) r_cur_y    <= vidc_d[23:14];
                    if (w_addr == 8'hBC) r_cur_yend <= vidc_d[23:14];
                end else begin
                    r_spec_wr  <= 1'b1;
                    r_spec     <= {16'h0, w_addr};
                    r_spec_dat <= vidc_d[23:0];
                end
            end
            // A change landing with an ack edge must survive for the MCU to see.
            if (w_treg_chg) begin
                r_tregs_status <= 1'b1;
            end else if (w_ack_rise) begin
                r_tregs_status <= 1'b0;
            end
        end
    end

    assign vidc_palette         = r_palette;
    assign vidc_cursor_palette  = r_cpal;
    assign v_cursor_x           = r_cur_x;
    assign v_cursor_y           = r_cur_y;
    assign v_cursor_yend        = r_cur_yend;
    assign vidc_special_written = r_spec_wr;
    assign vidc_special         = r_spec;
    assign vidc_special_data    = r_spec_dat;
    assign vidc_tregs_status    = r_tregs_status;
    assign treg_rdata           = r_treg[treg_sel];

`ifdef VIDC_WRITE_LOG_EN
    logic       w_log_full;
    logic [7:0] r_log_ovf;

    vidc_log_fifo #(.W(32), .DEPTH(16)) u_log_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_push_vld (w_accept),
        .i_push_dat (vidc_d),
        .i_pop_rdy  (log_rd),
        .o_head_dat (log_data),
        .o_empty    (log_empty),
        .o_full     (w_log_full)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_log_ovf <= '0;
        end else if (w_accept && w_log_full && !log_rd && (r_log_ovf != 8'hFF)) begin
            r_log_ovf <= r_log_ovf + 1'b1;
        end
    end

    assign log_ovf = r_log_ovf;
`endif
endmodule
